// File: rtl/flash_sample_prefetch.sv
// flash_sample_prefetch: walks a circular flash window into a small FIFO and hands one stereo word per sample request.
module flash_sample_prefetch #(
  parameter logic [23:0] BASE_ADDR  = 24'h000000,
  parameter logic [23:0] SIZE_BYTES = 24'h0ea600,
  parameter int          DEPTH      = 8,
  parameter bit          SWAP_BYTES = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  output logic                     flash_valid_o,
  output logic [23:0]              flash_addr_o,
  input  logic                     flash_ready_i,
  input  logic [31:0]              flash_rdata_i,
  input  logic                     sample_req_i,
  output logic [31:0]              sample_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     wrap_o,
  output logic [15:0]              underrun_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [23:0] LAST_ADDR = BASE_ADDR + SIZE_BYTES - 24'd4;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q, count_d;
  logic [23:0] addr_q;
  logic [31:0] sample_q, push_word;
  logic [15:0] unr_q;
  logic wrap_q, push, pop;
  assign push = state_q == FETCH && flash_ready_i;
  assign pop = sample_req_i && count_q != '0;
  assign push_word = SWAP_BYTES ? {flash_rdata_i[23:16], flash_rdata_i[31:24], flash_rdata_i[7:0], flash_rdata_i[15:8]}
                                : flash_rdata_i;
  always_comb begin
    state_d = state_q == IDLE ? ((enable_i && count_q < FULL) ? FETCH : IDLE)
                              : (flash_ready_i ? IDLE : FETCH);
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= BASE_ADDR;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      sample_q <= '0;
      wrap_q   <= 1'b0;
      unr_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= push && addr_q == LAST_ADDR;
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
        addr_q <= addr_q == LAST_ADDR ? BASE_ADDR : addr_q + 24'd4;
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      // an empty FIFO mutes the output; a same-cycle push never bypasses
      if (sample_req_i) sample_q <= pop ? mem_q[rptr_q] : '0;
      if (sample_req_i && !pop && unr_q != 16'hFFFF) unr_q <= unr_q + 16'd1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= push_word;
  end
  assign flash_valid_o  = state_q == FETCH;
  assign flash_addr_o   = addr_q;
  assign sample_o       = sample_q;
  assign level_o        = count_q;
  assign wrap_o         = wrap_q;
  assign underrun_cnt_o = unr_q;
  no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && count_q == FULL))
    else $error("push into full FIFO");
endmodule

// File: tb/tb_flash_sample_prefetch.sv
// tb_flash_sample_prefetch: two instances (default, and 16-byte window / depth 4 / byte swap) against a queue-level model.
module tb_flash_sample_prefetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic rst[2], en[2], req[2], rr[2], frc[2], rdy[2];
  logic [31:0] rd[2], so[2];
  logic fv[2], wr[2];
  logic [23:0] fa[2];
  logic [15:0] uc[2];
  logic [3:0] lv_a;
  logic [2:0] lv_b;
  logic ovr_en;
  logic [31:0] ovr;
  int cnt[2];

  function automatic logic [31:0] swap_halves(input logic [31:0] w);
    return {w[23:16], w[31:24], w[7:0], w[15:8]};
  endfunction
  function automatic logic [31:0] lvl(input int k);
    return k == 1 ? {29'b0, lv_b} : {28'b0, lv_a};
  endfunction
  function automatic int depth_of(input int k);
    return k == 1 ? 4 : 8;
  endfunction
  function automatic logic [23:0] last_of(input int k);
    return k == 1 ? 24'h00000c : 24'h0ea5fc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  assign rdy[0] = rr[0] | frc[0];
  assign rdy[1] = rr[1] | frc[1];
  assign rd[0] = {8'h00, fa[0]};
  assign rd[1] = ovr_en ? ovr : swap_halves({8'h00, fa[1]});

  flash_sample_prefetch u_a (
    .clk_i(clk), .rst_i(rst[0]), .enable_i(en[0]), .flash_valid_o(fv[0]), .flash_addr_o(fa[0]),
    .flash_ready_i(rdy[0]), .flash_rdata_i(rd[0]), .sample_req_i(req[0]), .sample_o(so[0]),
    .level_o(lv_a), .wrap_o(wr[0]), .underrun_cnt_o(uc[0]));

  flash_sample_prefetch #(.SIZE_BYTES(24'h000010), .DEPTH(4), .SWAP_BYTES(1'b1)) u_b (
    .clk_i(clk), .rst_i(rst[1]), .enable_i(en[1]), .flash_valid_o(fv[1]), .flash_addr_o(fa[1]),
    .flash_ready_i(rdy[1]), .flash_rdata_i(rd[1]), .sample_req_i(req[1]), .sample_o(so[1]),
    .level_o(lv_b), .wrap_o(wr[1]), .underrun_cnt_o(uc[1]));

  // flash reader: ready pulses on the third cycle of a request
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (fv[k] !== 1'b1) begin
        cnt[k] = 0;
        rr[k] = 1'b0;
      end else begin
        cnt[k]++;
        rr[k] = cnt[k] == 3;
      end
    end
  end

  logic [31:0] mq[2][8];
  int mh[2], mn[2], accs[2], wraps[2];
  logic [23:0] ma[2];
  logic [31:0] ms[2];
  logic [15:0] mu[2];
  logic mw[2], mv[2], live[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin : mdl
      int n0;
      logic acc;
      if (live[k]) begin
        chk("level", lvl(k), 32'(mn[k]));
        chk("valid", 32'(fv[k]), 32'(mv[k]));
        chk("addr", 32'(fa[k]), 32'(ma[k]));
        chk("sample", so[k], ms[k]);
        chk("wrap", 32'(wr[k]), 32'(mw[k]));
        chk("underrun", 32'(uc[k]), 32'(mu[k]));
        if (wr[k] === 1'b1) wraps[k]++;
      end
      if (rst[k]) begin
        mn[k] = 0; mh[k] = 0; ma[k] = '0; ms[k] = '0; mu[k] = '0;
        mw[k] = 1'b0; mv[k] = 1'b0; live[k] = 1'b1;
      end else if (live[k]) begin
        n0 = mn[k];
        acc = mv[k] && rdy[k];
        if (req[k] && n0 > 0) begin
          ms[k] = mq[k][mh[k]];
          mh[k] = (mh[k] + 1) % 8;
          mn[k]--;
        end else if (req[k]) begin
          ms[k] = '0;
          if (mu[k] != 16'hFFFF) mu[k]++;
        end
        mw[k] = acc && ma[k] == last_of(k);
        if (acc) begin
          chk("no_overflow", 32'(n0 < depth_of(k)), 32'd1);
          mq[k][(mh[k] + mn[k]) % 8] = k == 1 ? swap_halves(rd[k]) : rd[k];
          mn[k]++;
          ma[k] = ma[k] == last_of(k) ? 24'h0 : ma[k] + 24'd4;
          accs[k]++;
        end
        mv[k] = mv[k] ? !acc : (en[k] && n0 < depth_of(k));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_inst(input int k, input logic enable);
    rst[k] = 1'b1;
    en[k] = enable;
    tick();
    rst[k] = 1'b0;
  endtask

  logic [31:0] pops[16];
  logic [31:0] exp_pops[5] = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h0};
  int np;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; en[k] = 1'b0; req[k] = 1'b0; frc[k] = 1'b0; rr[k] = 1'b0;
      live[k] = 1'b0; accs[k] = 0; wraps[k] = 0; cnt[k] = 0;
    end
    ovr_en = 1'b0;
    ovr = '0;
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    // fill to full, then stay quiet
    reset_inst(0, 1'b1);
    for (int i = 0; i < 200 && lv_a != 4'd8; i++) tick();
    chk("t1_level_full", 32'(lv_a), 32'd8);
    chk("t1_next_addr", 32'(fa[0]), 32'h20);
    repeat (20) tick();
    chk("t1_idle_when_full", 32'(fv[0]), 32'd0);
    // reset abandons an in-flight request at 0x8
    reset_inst(0, 1'b1);
    for (int i = 0; i < 100 && !(fv[0] && fa[0] == 24'h8); i++) tick();
    chk("t5_fetch_at_8", 32'(fv[0] && fa[0] == 24'h8), 32'd1);
    req[0] = 1'b1;
    tick();
    tick();
    req[0] = 1'b0;
    chk("t5_sample_before", so[0], 32'h4);
    rst[0] = 1'b1;
    en[0] = 1'b0;
    tick();
    rst[0] = 1'b0;
    chk("t5_valid", 32'(fv[0]), 32'd0);
    chk("t5_addr", 32'(fa[0]), 32'd0);
    chk("t5_level", 32'(lv_a), 32'd0);
    chk("t5_sample", so[0], 32'd0);
    frc[0] = 1'b1;
    tick();
    frc[0] = 1'b0;
    chk("t5_late_ready", 32'(lv_a), 32'd0);
    // enable drop mid-fetch
    reset_inst(0, 1'b1);
    for (int i = 0; i < 20 && fv[0] !== 1'b1; i++) tick();
    en[0] = 1'b0;
    repeat (20) tick();
    chk("t6_level", 32'(lv_a), 32'd1);
    chk("t6_valid", 32'(fv[0]), 32'd0);
    chk("t6_addr", 32'(fa[0]), 32'h4);
    en[0] = 1'b1;
    for (int i = 0; i < 20 && fv[0] !== 1'b1; i++) tick();
    chk("t6_resume_addr", 32'(fv[0] ? fa[0] : 24'hffffff), 32'h4);
    for (int i = 0; i < 20 && lv_a != 4'd2; i++) tick();
    chk("t6_level2", 32'(lv_a), 32'd2);
    en[0] = 1'b0;
    // underruns
    reset_inst(0, 1'b0);
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    chk("t3_mute", so[0], 32'd0);
    chk("t3_unr1", 32'(uc[0]), 32'd1);
    repeat (3) begin
      req[0] = 1'b1;
      tick();
      req[0] = 1'b0;
      tick();
    end
    chk("t3_unr4", 32'(uc[0]), 32'd4);
    en[0] = 1'b1;
    for (int i = 0; i < 20 && rdy[0] !== 1'b1; i++) tick();
    req[0] = 1'b1;
    en[0] = 1'b0;
    tick();
    req[0] = 1'b0;
    chk("t3_unr5", 32'(uc[0]), 32'd5);
    chk("t3_level1", 32'(lv_a), 32'd1);
    // 16-byte window, depth 4
    reset_inst(1, 1'b1);
    for (int i = 0; i < 100 && lv_b != 3'd4; i++) tick();
    chk("t2_full", 32'(lv_b), 32'd4);
    np = 0;
    for (int i = 0; i < 110; i++) begin
      req[1] = i % 10 == 0;
      tick();
      if (req[1]) begin
        pops[np] = so[1];
        np++;
      end
    end
    req[1] = 1'b0;
    en[1] = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 5; i++) chk("t2_pop_seq", pops[i], exp_pops[i]);
    chk("t2_accepts", 32'(accs[1] >= 8), 32'd1);
    chk("t2_wrap_count", 32'(wraps[1]), 32'(accs[1] / 4));
    // byte swap
    reset_inst(1, 1'b0);
    ovr = 32'h11223344;
    ovr_en = 1'b1;
    en[1] = 1'b1;
    for (int i = 0; i < 20 && lv_b != 3'd1; i++) tick();
    en[1] = 1'b0;
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    chk("t4_swap", so[1], 32'h22114433);
    chk("t4_level", 32'(lv_b), 32'd0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
